reg_dump_tx: RTL and testbench
==============================

REG_DUMP_TX -- requirements
Module: reg_dump_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (115200 baud at 100 MHz); legal range 4..65535.
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL provide port start  input  1  one-cycle request to dump the register file.
REQ-005 SHALL provide ports r0_in, r1_in, r2_in, r3_in  input  8 each  register-file debug values R0..R3.
REQ-006 SHALL provide port tx  output  1  UART 8N1 serial line, idle high.
REQ-007 SHALL provide port busy  output  1  high from snapshot until the last stop bit completes.
REQ-008 SHALL provide port done  output  1  one-cycle pulse at end of dump.

Function
REQ-009 SHALL use states IDLE, START_BIT, DATA_BITS, STOP_BIT, FINISH.
REQ-010 In IDLE with start=1 at edge k: SHALL snapshot r0_in..r3_in into internal 8-bit holding registers, set busy=1 and enter START_BIT; tx=0 from cycle k+1.
REQ-011 SHALL ignore start while busy=1; snapshot values SHALL NOT change during a dump, regardless of r*_in activity.
REQ-012 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads at every bit boundary.
REQ-013 Frame: start bit 0, 8 data bits LSB first, stop bit 1; 10*CLKS_PER_BIT cycles per frame.
REQ-014 Byte order SHALL be R0, R1, R2, R3 (preceded by header per REQ-024 when enabled).
REQ-015 After STOP_BIT of a non-final byte: SHALL advance the byte index and enter START_BIT on the next cycle, with no idle gap between frames.
REQ-016 After STOP_BIT of the final byte: SHALL enter FINISH for one cycle with done=1 and busy=0, then return to IDLE.
REQ-017 start=1 in the FINISH cycle SHALL be ignored; start is accepted only in IDLE.
REQ-018 A 4-byte dump SHALL occupy 40*CLKS_PER_BIT cycles from the first tx low to the end of the last stop bit.
REQ-019 tx SHALL be driven from a register (glitch-free); busy and done SHALL be registered.

Reset
REQ-020 rst_n=0 SHALL immediately force state=IDLE, tx=1, busy=0, done=0, baud counter=0, bit index=0, byte index=0 and holding registers=0x00.
REQ-021 Reset asserted mid-frame SHALL abort the dump with no done pulse; after release, a new start SHALL begin a fresh dump from the first byte.
REQ-022 Reset release SHALL be consumed synchronously; start SHALL be sampled no earlier than the first rising edge after rst_n=1.

Configuration
REQ-023 Macro REG_DUMP_HEADER_EN SHALL select header framing.
REQ-024 With REG_DUMP_HEADER_EN defined: SHALL send sync byte 0xA5 before R0, giving 5 frames and 50*CLKS_PER_BIT cycles; without it, only 4 frames (R0..R3) and no header logic.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-025 Reset then start with r0..r3=0x01,0x80,0xFF,0x3C -> tx decodes 0x01,0x80,0xFF,0x3C; busy high for 160 cycles; single done pulse.
REQ-026 Changing r0..r3 to 0x00 one cycle after start -> transmitted bytes remain the original snapshot.
REQ-027 Second start pulse at cycle 50 of a dump -> ignored; exactly 4 frames sent and exactly one done pulse.
REQ-028 rst_n low during bit 3 of R1 -> tx=1 and busy=0 immediately, no done pulse; next start sends R0 first.
REQ-029 REG_DUMP_HEADER_EN defined, r0..r3=0x11,0x22,0x33,0x44 -> bytes 0xA5,0x11,0x22,0x33,0x44; busy lasts 200 cycles.
REQ-030 CLKS_PER_BIT=868 -> every bit period measures exactly 868 cycles; start-to-first-falling-edge latency 1 cycle.

Source files
------------

// File: rtl/reg_dump_tx.sv
// reg_dump_tx: streams a snapshot of debug registers R0..R3 out of a UART 8N1 line
//
// Build option: define REG_DUMP_HEADER_EN to send sync byte 0xA5 ahead of R0
// (5 frames per dump instead of 4).
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (4..65535)
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   start         one-cycle dump request, accepted only in IDLE
//   r0_in..r3_in  register values, captured when a dump is accepted
//   tx            serial output, idle high
//   busy          high from the snapshot until the last stop bit completes
//   done          one-cycle pulse at the end of a dump
module reg_dump_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] r0_in,
    input  logic [7:0] r1_in,
    input  logic [7:0] r2_in,
    input  logic [7:0] r3_in,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START_BIT = 3'd1;
    localparam logic [2:0] DATA_BITS = 3'd2;
    localparam logic [2:0] STOP_BIT  = 3'd3;
    localparam logic [2:0] FINISH    = 3'd4;
    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
`ifdef REG_DUMP_HEADER_EN
    localparam int BYTE_W = 3;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(4);
`else
    localparam int BYTE_W = 2;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(3);
`endif
    logic [2:0]        state_q, state_d;
    logic [15:0]       baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [31:0]       hold_q, hold_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        cur_byte;
    logic              bit_end;
    assign bit_end = baud_q == 16'd0;
`ifdef REG_DUMP_HEADER_EN
    logic [1:0] rsel;
    // Frame 0 is the sync byte, so register frames are offset by one.
    assign rsel     = 2'(byte_q - BYTE_W'(1));
    assign cur_byte = (byte_q == '0) ? 8'hA5 : hold_q[{rsel, 3'b000} +: 8];
`else
    assign cur_byte = hold_q[{byte_q, 3'b000} +: 8];
`endif
    // The tx register is loaded with the level of the bit being entered, so
    // the line changes exactly on bit boundaries with no combinational path.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        hold_d  = hold_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = START_BIT;
                    baud_d  = BAUD_MAX;
                    bit_d   = 3'd0;
                    byte_d  = '0;
                    hold_d  = {r3_in, r2_in, r1_in, r0_in};
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    state_d = DATA_BITS;
                    baud_d  = BAUD_MAX;
                    bit_d   = 3'd0;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    baud_d = BAUD_MAX;
                    if (bit_q == 3'd7) begin
                        state_d = STOP_BIT;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            STOP_BIT: begin
                if (bit_end) begin
                    if (byte_q == LAST_BYTE) begin
                        state_d = FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Next frame's start bit follows immediately.
                        state_d = START_BIT;
                        baud_d  = BAUD_MAX;
                        byte_d  = byte_q + BYTE_W'(1);
                        tx_d    = 1'b0;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                byte_d  = '0;
                bit_d   = 3'd0;
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            hold_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            hold_q  <= hold_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_reg_dump_tx.sv
// tb_reg_dump_tx: self-checking bench for reg_dump_tx with a byte scoreboard
module tb_reg_dump_tx;
    localparam int CPB = 4;
    localparam int SLOW = 868;
`ifdef REG_DUMP_HEADER_EN
    localparam int NFR = 5;
`else
    localparam int NFR = 4;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       s_start = 1'b0;
    logic [7:0] r0 = 8'h00, r1 = 8'h00, r2 = 8'h00, r3 = 8'h00;
    logic       tx, busy, done;
    logic       s_tx, s_busy, s_done;
    int         total = 0;
    int         bad = 0;
    int         busy_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] exp_q[$];

    reg_dump_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .r0_in(r0), .r1_in(r1), .r2_in(r2), .r3_in(r3),
        .tx(tx), .busy(busy), .done(done)
    );

    reg_dump_tx #(.CLKS_PER_BIT(SLOW)) u_slow (
        .clk(clk), .rst_n(rst_n), .start(s_start),
        .r0_in(8'h55), .r1_in(8'h55), .r2_in(8'h55), .r3_in(8'h55),
        .tx(s_tx), .busy(s_busy), .done(s_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Decode every frame on tx, require each bit to hold for exactly CPB cycles,
    // and compare the byte against the head of the scoreboard.
    initial begin : mon
        logic [9:0] f;
        bit ok, ab;
        forever begin
            @(negedge clk);
            if (rst_n && busy && !tx) begin
                ok = 1'b1;
                ab = 1'b0;
                for (int j = 0; j < 10; j++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (j > 0 || c > 0) @(negedge clk);
                        if (!rst_n) begin
                            ab = 1'b1;
                            break;
                        end
                        if (c == 0) f[j] = tx;
                        else if (tx !== f[j]) ok = 1'b0;
                    end
                    if (ab) break;
                end
                if (!ab) begin
                    chk("frame_shape", {29'd0, ok, f[0], f[9]}, 32'h5);
                    chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) chk("byte", {24'd0, f[8:1]}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        @(posedge clk);
        #1;
        r0 = a; r1 = b; r2 = c; r3 = d;
        busy_cnt = 0;
        done_cnt = 0;
`ifdef REG_DUMP_HEADER_EN
        exp_q.push_back(8'hA5);
`endif
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("lat_tx_low", {31'd0, tx}, 32'd0);
        chk("lat_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < NFR * 10 * CPB + 20; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic post_checks(input string tag);
        repeat (5) @(negedge clk);
        chk({tag, "_busy_len"}, busy_cnt, NFR * 10 * CPB);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
        chk({tag, "_idle_tx"}, {31'd0, tx}, 32'd1);
    endtask

    initial begin
        int n;
        logic lvl;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        do_start(8'h01, 8'h80, 8'hFF, 8'h3C);
        wait_done();
        post_checks("basic");

        do_start(8'hAA, 8'h55, 8'h0F, 8'hF0);
        r0 = 8'h00; r1 = 8'h00; r2 = 8'h00; r3 = 8'h00;
        wait_done();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("finish_start_ign", {31'd0, busy}, 32'd0);
        post_checks("snap");

        do_start(8'h12, 8'h34, 8'h56, 8'h78);
        repeat (48) @(posedge clk);
        #1;
        r0 = 8'hEE; r1 = 8'hEE; r2 = 8'hEE; r3 = 8'hEE;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        post_checks("restart");
        repeat (15 * CPB) @(negedge clk);
        chk("restart_quiet", {31'd0, busy}, 32'd0);
        chk("restart_done_cnt", done_cnt, 1);

        do_start(8'hC3, 8'h5A, 8'h99, 8'h66);
        repeat ((NFR - 3) * 10 * CPB + 4 * CPB + 1) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx", {31'd0, tx}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        do_start(8'h9E, 8'h01, 8'h02, 8'h03);
        wait_done();
        post_checks("after_abort");

        @(posedge clk);
        #1 s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        chk("slow_lat", {31'd0, s_tx}, 32'd0);
        n = 0;
        lvl = 1'b0;
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < SLOW + 10; i++) begin
                @(negedge clk);
                if (s_tx != lvl) break;
                n++;
            end
            chk("slow_bit_len", n, SLOW);
            lvl = s_tx;
            n = 1;
        end
        for (int i = 0; i < 40 * SLOW; i++) begin
            @(negedge clk);
            if (s_done) break;
        end
        chk("slow_done", {31'd0, s_done}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
